// File: rtl/vga_cursor_pkg.sv
// Shared defaults for the text-mode cursor/blink generator family.
package vga_cursor_pkg;
  localparam int DEF_MAX_SKEW    = 3;
  localparam int DEF_SKEW_W      = 2;
  localparam int DEF_BLINK_W     = 5;
  localparam int DEF_RSEL_W      = 3;
  localparam int DEF_SCAN_W      = 5;
  // Blink-counter bit that reproduces the legacy 16/32-frame cursor rate.
  localparam int LEGACY_RATE_SEL = 3;
endpackage

// File: rtl/cursor_skew_pipe.sv
// Cursor-attribute skew pipe: advances on each character load and selects a
// tap by the programmed skew; overrange skew clamps to the deepest tap.
module cursor_skew_pipe #(
  parameter int MAX_SKEW = 3,
  parameter int SKEW_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_ld,
  input  logic              din,
  input  logic [SKEW_W-1:0] skew,
  output logic              dout
);
  logic [MAX_SKEW-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d[0] = din;
    for (int k = 1; k < MAX_SKEW; k++) pipe_d[k] = pipe_q[k-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           pipe_q <= '0;
    else if (shift_ld) pipe_q <= pipe_d;
  end

  // Last tap with k < skew wins, which also clamps skew > MAX_SKEW.
  always_comb begin
    dout = din;
    for (int k = 0; k < MAX_SKEW; k++)
      if (int'(skew) > k) dout = pipe_q[k];
  end
endmodule

// File: rtl/text_cursor_gen.sv
// Text-mode cursor generator: skewed cursor attribute, scan-line window,
// vsync-driven blink counter and final cursor bit for the serializer.
module text_cursor_gen
  import vga_cursor_pkg::*;
#(
  parameter int MAX_SKEW = DEF_MAX_SKEW,
  parameter int SKEW_W   = DEF_SKEW_W,
  parameter int BLINK_W  = DEF_BLINK_W,
  parameter int RSEL_W   = DEF_RSEL_W,
  parameter int SCAN_W   = DEF_SCAN_W,
  parameter bit REG_OUT  = 1'b0
) (
  input  logic              t_crt_clk,
  input  logic              h_reset,
  input  logic              c_shift_ld,
  input  logic              m_att_cursor,
  input  logic [SKEW_W-1:0] c_cursor_skew,
  input  logic              c_cursor_dis,
  input  logic [SCAN_W-1:0] c_cur_start,
  input  logic [SCAN_W-1:0] c_cur_end,
  input  logic [SCAN_W-1:0] c_row_scan,
  input  logic              c_t_vsync,
  input  logic              ar12_b4,
  input  logic [RSEL_W-1:0] c_cur_rate_sel,
  output logic              cursor_blink_rate,
  output logic              char_blink_rate,
  output logic              vsync_rise,
  output logic              finalcursor
);
  localparam int SEL_MAX = BLINK_W - 2;

  logic               skew_out;
  logic               vs_q;
  logic [BLINK_W-1:0] blink_q, blink_d;
  logic               bsel;
  logic               in_win;
  logic               cur;

  cursor_skew_pipe #(.MAX_SKEW(MAX_SKEW), .SKEW_W(SKEW_W)) u_skew (
    .clk      (t_crt_clk),
    .rst      (h_reset),
    .shift_ld (c_shift_ld),
    .din      (m_att_cursor),
    .skew     (c_cursor_skew),
    .dout     (skew_out)
  );

  // vs_q resets high so a vsync already asserted at release is not counted.
  assign vsync_rise = c_t_vsync & ~vs_q;

  always_comb begin
    blink_d = blink_q;
    if (ar12_b4)         blink_d = '0;
    else if (vsync_rise) blink_d = blink_q + {{(BLINK_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge t_crt_clk or posedge h_reset) begin
    if (h_reset) begin
      vs_q    <= 1'b1;
      blink_q <= '0;
    end else begin
      vs_q    <= c_t_vsync;
      blink_q <= blink_d;
    end
  end

  // Rate select clamps to BLINK_W-2 so the cursor always outpaces char blink.
  always_comb begin
    bsel = blink_q[0];
    for (int k = 0; k <= SEL_MAX; k++)
      if (int'(c_cur_rate_sel) >= k) bsel = blink_q[k];
  end

  assign cursor_blink_rate = ~bsel;
  assign char_blink_rate   = blink_q[BLINK_W-1];

  assign in_win = (c_cur_start <= c_cur_end) &&
                  (c_row_scan >= c_cur_start) && (c_row_scan <= c_cur_end);

  assign cur = skew_out & cursor_blink_rate & in_win & ~c_cursor_dis;

  generate
    if (REG_OUT) begin : g_reg
      logic fc_q;
      always_ff @(posedge t_crt_clk or posedge h_reset) begin
        if (h_reset) fc_q <= 1'b0;
        else         fc_q <= cur;
      end
      assign finalcursor = fc_q;
    end else begin : g_comb
      assign finalcursor = cur;
    end
  endgenerate
endmodule

// File: tb/tb_text_cursor_gen.sv
// Directed bench: combinational/registered output instances plus a wide-skew
// instance sharing all other inputs.
module tb_text_cursor_gen;
  logic       clk = 1'b0;
  logic       rst;
  logic       ld, att, dis, vs, ar12;
  logic [1:0] skew;
  logic [2:0] skew_c;
  logic [4:0] cstart, cend, scan;
  logic [2:0] rsel;

  logic cbr_a, chr_a, rise_a, fc_a;
  logic cbr_b, chr_b, rise_b, fc_b;
  logic cbr_c, chr_c, rise_c, fc_c;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  text_cursor_gen #(.REG_OUT(1'b0)) u_a (
    .t_crt_clk(clk), .h_reset(rst), .c_shift_ld(ld), .m_att_cursor(att),
    .c_cursor_skew(skew), .c_cursor_dis(dis), .c_cur_start(cstart),
    .c_cur_end(cend), .c_row_scan(scan), .c_t_vsync(vs), .ar12_b4(ar12),
    .c_cur_rate_sel(rsel), .cursor_blink_rate(cbr_a), .char_blink_rate(chr_a),
    .vsync_rise(rise_a), .finalcursor(fc_a));

  text_cursor_gen #(.REG_OUT(1'b1)) u_b (
    .t_crt_clk(clk), .h_reset(rst), .c_shift_ld(ld), .m_att_cursor(att),
    .c_cursor_skew(skew), .c_cursor_dis(dis), .c_cur_start(cstart),
    .c_cur_end(cend), .c_row_scan(scan), .c_t_vsync(vs), .ar12_b4(ar12),
    .c_cur_rate_sel(rsel), .cursor_blink_rate(cbr_b), .char_blink_rate(chr_b),
    .vsync_rise(rise_b), .finalcursor(fc_b));

  text_cursor_gen #(.SKEW_W(3), .REG_OUT(1'b0)) u_c (
    .t_crt_clk(clk), .h_reset(rst), .c_shift_ld(ld), .m_att_cursor(att),
    .c_cursor_skew(skew_c), .c_cursor_dis(dis), .c_cur_start(cstart),
    .c_cur_end(cend), .c_row_scan(scan), .c_t_vsync(vs), .ar12_b4(ar12),
    .c_cur_rate_sel(rsel), .cursor_blink_rate(cbr_c), .char_blink_rate(chr_c),
    .vsync_rise(rise_c), .finalcursor(fc_c));

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vpulse();
    vs = 1'b1; tick();
    vs = 1'b0; tick();
  endtask

  initial begin
    logic [4:0]  ev;
    logic [15:0] pat;
    rst = 1'b1; ld = 1'b0; att = 1'b1; dis = 1'b0; vs = 1'b1; ar12 = 1'b0;
    skew = 2'd0; skew_c = 3'd0; cstart = 5'd0; cend = 5'd31; scan = 5'd0;
    rsel = 3'd3;
    #12;
    chk("rst_cbr", cbr_a, 1'b1);
    chk("rst_char", chr_a, 1'b0);
    chk("rst_rise", rise_a, 1'b0);
    chk("rst_fc_reg", fc_b, 1'b0);
    chk("rst_fc_comb", fc_a, 1'b1);

    // Release with vsync already high: no edge, no count.
    @(negedge clk); rst = 1'b0;
    #1 chk("rel_rise", rise_a, 1'b0);
    tick();
    chk("rel_char", chr_a, 1'b0);
    chk("rel_cbr", cbr_a, 1'b1);
    vs = 1'b0; tick();

    // 32 vsync edges at defaults.
    for (int i = 1; i <= 32; i++) begin
      vs = 1'b1; #1;
      chk("vs_rise", rise_a, 1'b1);
      tick();
      chk("vs_rise_once", rise_a, 1'b0);
      vs = 1'b0; tick();
      ev = 5'(i);
      chk("blink_char", chr_a, ev[4]);
      chk("blink_cbr", cbr_a, ~ev[3]);
    end
    chk("wrap_char", chr_a, 1'b0);
    chk("wrap_cbr", cbr_a, 1'b1);

    // Count to 24 (11000b), then clear coincident with a rising edge.
    for (int i = 0; i < 24; i++) vpulse();
    chk("c24_char", chr_a, 1'b1);
    chk("c24_cbr", cbr_a, 1'b0);
    vs = 1'b1; ar12 = 1'b1; #1;
    chk("clr_rise", rise_a, 1'b1);
    tick();
    chk("clr_cbr", cbr_a, 1'b1);
    chk("clr_char", chr_a, 1'b0);
    ar12 = 1'b0; vs = 1'b0; tick();
    chk("clr_hold_char", chr_a, 1'b0);

    // Rate select.
    rsel = 3'd0;
    vpulse(); chk("rs0_c1", cbr_a, 1'b0);
    vpulse(); chk("rs0_c2", cbr_a, 1'b1);
    vpulse(); chk("rs0_c3", cbr_a, 1'b0);
    for (int i = 0; i < 5; i++) vpulse();
    rsel = 3'd7; #1 chk("rs7_clamp_c8", cbr_a, 1'b0);
    rsel = 3'd2; #1 chk("rs2_c8", cbr_a, 1'b1);
    rsel = 3'd3;
    ar12 = 1'b1; tick(); ar12 = 1'b0; tick();
    chk("rs_cleared", cbr_a, 1'b1);

    // Skew sweep: flush pipe, then a single 1 followed by zeros.
    for (int k = 0; k < 4; k++) begin
      skew = 2'(k);
      skew_c = (k == 3) ? 3'd7 : 3'(k);
      att = 1'b0; ld = 1'b1;
      for (int f = 0; f < 3; f++) tick();
      ld = 1'b0; tick();
      for (int j = 0; j < 5; j++) begin
        att = (j == 0); ld = 1'b1; #1;
        chk("skew_a", fc_a, (j == k));
        chk("skew_c", fc_c, (j == k));
        tick();
        att = 1'b0; ld = 1'b0; tick();
      end
    end

    // Scan-line window with live cursor.
    skew = 2'd0; skew_c = 3'd0; att = 1'b1;
    cstart = 5'd13; cend = 5'd14;
    for (int s = 0; s < 32; s++) begin
      scan = 5'(s); #1 chk("win_13_14", fc_a, (s == 13 || s == 14));
    end
    cstart = 5'd14; cend = 5'd13;
    for (int s = 0; s < 32; s++) begin
      scan = 5'(s); #1 chk("win_inverted", fc_a, 1'b0);
    end
    cstart = 5'd0; cend = 5'd0;
    for (int s = 0; s < 32; s++) begin
      scan = 5'(s); #1 chk("win_0_0", fc_a, (s == 0));
    end
    scan = 5'd0; dis = 1'b1; #1 chk("cursor_dis", fc_a, 1'b0);
    dis = 1'b0;
    tick();

    // Registered output lags the combinational one by exactly one cycle.
    pat = 16'hA5C3;
    for (int i = 0; i < 16; i++) begin
      att = pat[i]; #1;
      chk("lag_comb", fc_a, pat[i]);
      tick();
      chk("lag_reg", fc_b, pat[i]);
    end

    // Mid-frame async reset at count 17: char=1, cursor visible, rise pending.
    ar12 = 1'b1; tick(); ar12 = 1'b0; tick();
    for (int i = 0; i < 17; i++) vpulse();
    att = 1'b1; tick();
    chk("pre_char", chr_a, 1'b1);
    chk("pre_fc_reg", fc_b, 1'b1);
    vs = 1'b1; #1 chk("pre_rise", rise_a, 1'b1);
    #2 rst = 1'b1; #1;
    chk("mid_char", chr_a, 1'b0);
    chk("mid_cbr", cbr_a, 1'b1);
    chk("mid_rise", rise_a, 1'b0);
    chk("mid_fc_reg", fc_b, 1'b0);
    chk("mid_char_b", chr_b, 1'b0);
    @(negedge clk); rst = 1'b0; vs = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
